// File: rtl/keynsham_rom_arbiter.sv
// Arbiter that lets the CPU instruction and data buses share one synchronous-read boot ROM.
// Each cycle it picks one bus, drives the ROM address, and returns the read data and an ack on the next cycle.
module keynsham_rom_arbiter #(
    parameter int unsigned AW         = 11,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_access,
    input  logic             i_cs,
    input  logic [29:0]      i_addr,
    output logic [31:0]      i_data,
    output logic             i_ack,
    input  logic             d_access,
    input  logic             d_cs,
    input  logic [29:0]      d_addr,
    output logic [31:0]      d_data,
    output logic             d_ack,
    output logic [AW-1:0]    rom_addr,
    output logic             rom_en,
    input  logic [31:0]      rom_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    logic             i_req;
    logic             d_req;
    logic             both_req;
    logic             grant_i;
    logic             grant_d;

    gnt_e             last_gnt_q, last_gnt_d;
    logic             gnt_i_q, gnt_i_d;
    logic             gnt_d_q, gnt_d_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    // The ROM only sees the low word-address bits; the rest come from chip-select decode.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[29:AW], d_addr[29:AW]};

    assign i_req    = i_access & i_cs;
    assign d_req    = d_access & d_cs;
    assign both_req = i_req & d_req;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (both_req) begin
            if (FIXED_PRIO || (last_gnt_q == GNT_D)) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end

    always_comb begin
        rom_addr = '0;
        if (grant_i) begin
            rom_addr = i_addr[AW-1:0];
        end else if (grant_d) begin
            rom_addr = d_addr[AW-1:0];
        end
    end

    assign rom_en = grant_i | grant_d;

    always_comb begin
        gnt_i_d        = grant_i;
        gnt_d_d        = grant_d;
        last_gnt_d     = last_gnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (grant_i) begin
            last_gnt_d = GNT_I;
        end else if (grant_d) begin
            last_gnt_d = GNT_D;
        end
        if (both_req && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // last_gnt resets to D so that the first conflict after reset goes to I.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            gnt_i_q        <= 1'b0;
            gnt_d_q        <= 1'b0;
            last_gnt_q     <= GNT_D;
            conflict_cnt_q <= '0;
        end else begin
            gnt_i_q        <= gnt_i_d;
            gnt_d_q        <= gnt_d_d;
            last_gnt_q     <= last_gnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign i_ack        = gnt_i_q;
    assign d_ack        = gnt_d_q;
    assign i_data       = gnt_i_q ? rom_rdata : 32'h0;
    assign d_data       = gnt_d_q ? rom_rdata : 32'h0;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_keynsham_rom_arbiter.sv
// Bench for keynsham_rom_arbiter: three instances (round-robin, fixed priority, 4-bit counter) share one stimulus.
// A per-cycle behavioural model checks all three instances, and some literal checks pin the expected values.
module tb_keynsham_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_access, i_cs, d_access, d_cs;
    logic [29:0] i_addr, d_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic [31:0] rr_i_data, rr_d_data, fp_i_data, fp_d_data, sat_i_data, sat_d_data;
    logic        rr_i_ack, rr_d_ack, fp_i_ack, fp_d_ack, sat_i_ack, sat_d_ack;
    logic [10:0] rr_rom_addr, fp_rom_addr, sat_rom_addr;
    logic        rr_rom_en, fp_rom_en, sat_rom_en;
    logic [31:0] rr_rdata, fp_rdata, sat_rdata;
    logic [15:0] rr_cnt, fp_cnt;
    logic [3:0]  sat_cnt;

    keynsham_rom_arbiter #(.AW(11), .FIXED_PRIO(1'b0), .CNT_W(16)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .i_access(i_access), .i_cs(i_cs), .i_addr(i_addr), .i_data(rr_i_data), .i_ack(rr_i_ack),
        .d_access(d_access), .d_cs(d_cs), .d_addr(d_addr), .d_data(rr_d_data), .d_ack(rr_d_ack),
        .rom_addr(rr_rom_addr), .rom_en(rr_rom_en), .rom_rdata(rr_rdata), .conflict_cnt(rr_cnt)
    );

    keynsham_rom_arbiter #(.AW(11), .FIXED_PRIO(1'b1), .CNT_W(16)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_access(i_access), .i_cs(i_cs), .i_addr(i_addr), .i_data(fp_i_data), .i_ack(fp_i_ack),
        .d_access(d_access), .d_cs(d_cs), .d_addr(d_addr), .d_data(fp_d_data), .d_ack(fp_d_ack),
        .rom_addr(fp_rom_addr), .rom_en(fp_rom_en), .rom_rdata(fp_rdata), .conflict_cnt(fp_cnt)
    );

    keynsham_rom_arbiter #(.AW(11), .FIXED_PRIO(1'b0), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .i_access(i_access), .i_cs(i_cs), .i_addr(i_addr), .i_data(sat_i_data), .i_ack(sat_i_ack),
        .d_access(d_access), .d_cs(d_cs), .d_addr(d_addr), .d_data(sat_d_data), .d_ack(sat_d_ack),
        .rom_addr(sat_rom_addr), .rom_en(sat_rom_en), .rom_rdata(sat_rdata), .conflict_cnt(sat_cnt)
    );

    function automatic logic [31:0] rom_fn(input logic [10:0] a);
        return {a, 10'h0, a} ^ 32'h5A3C_96E1;
    endfunction

    // ROM macros: one-cycle synchronous read, output holds when not enabled.
    always @(posedge clk) begin
        if (rr_rom_en)  rr_rdata  <= rom_fn(rr_rom_addr);
        if (fp_rom_en)  fp_rdata  <= rom_fn(fp_rom_addr);
        if (sat_rom_en) sat_rdata <= rom_fn(sat_rom_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ia, input logic [29:0] ia_addr, input logic da, input logic [29:0] da_addr);
        i_access = ia;
        i_cs     = ia;
        i_addr   = ia_addr;
        d_access = da;
        d_cs     = da;
        d_addr   = da_addr;
    endtask

    task automatic do_reset();
        drive(1'b0, 30'h0, 1'b0, 30'h0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Behavioural model: the outputs of each cycle follow from what the model remembers about the previous grant.
    bit          m_valid = 1'b0;
    bit          m_pend_i[3];
    bit          m_pend_d[3];
    logic [10:0] m_pend_addr[3];
    bit          m_last_was_d[3];
    int          m_cnt[3];

    initial begin : compare
        string       tag;
        bit          ireq, dreq, gi, gd;
        logic [10:0] exp_addr;
        logic        en, iack, dack;
        logic [10:0] addr;
        logic [31:0] idata, ddata, cnt;
        int          cmax;
        forever begin
            @(negedge clk);
            ireq = i_access & i_cs;
            dreq = d_access & d_cs;
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0: begin tag = "rr";  en = rr_rom_en;  addr = rr_rom_addr;  iack = rr_i_ack;  dack = rr_d_ack;
                             idata = rr_i_data;  ddata = rr_d_data;  cnt = {16'h0, rr_cnt}; end
                    1: begin tag = "fp";  en = fp_rom_en;  addr = fp_rom_addr;  iack = fp_i_ack;  dack = fp_d_ack;
                             idata = fp_i_data;  ddata = fp_d_data;  cnt = {16'h0, fp_cnt}; end
                    default: begin tag = "sat"; en = sat_rom_en; addr = sat_rom_addr; iack = sat_i_ack; dack = sat_d_ack;
                             idata = sat_i_data; ddata = sat_d_data; cnt = {28'h0, sat_cnt}; end
                endcase
                cmax = (k == 2) ? 15 : 65535;
                if (ireq && dreq) begin
                    gi = (k == 1) || m_last_was_d[k];
                    gd = !gi;
                end else begin
                    gi = ireq;
                    gd = dreq;
                end
                exp_addr = gi ? i_addr[10:0] : (gd ? d_addr[10:0] : 11'h0);
                if (m_valid) begin
                    check({tag, " rom_en"},   {31'h0, en},   {31'h0, gi | gd});
                    check({tag, " rom_addr"}, {21'h0, addr}, {21'h0, exp_addr});
                    check({tag, " i_ack"},    {31'h0, iack}, {31'h0, m_pend_i[k]});
                    check({tag, " d_ack"},    {31'h0, dack}, {31'h0, m_pend_d[k]});
                    check({tag, " i_data"},   idata, m_pend_i[k] ? rom_fn(m_pend_addr[k]) : 32'h0);
                    check({tag, " d_data"},   ddata, m_pend_d[k] ? rom_fn(m_pend_addr[k]) : 32'h0);
                    check({tag, " conflict_cnt"}, cnt, m_cnt[k]);
                end
                if (!rst_n) begin
                    m_pend_i[k]     = 1'b0;
                    m_pend_d[k]     = 1'b0;
                    m_pend_addr[k]  = 11'h0;
                    m_last_was_d[k] = 1'b1;
                    m_cnt[k]        = 0;
                end else begin
                    m_pend_i[k]    = gi;
                    m_pend_d[k]    = gd;
                    m_pend_addr[k] = exp_addr;
                    if (gi) m_last_was_d[k] = 1'b0;
                    if (gd) m_last_was_d[k] = 1'b1;
                    if (ireq && dreq && m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
                end
            end
            if (!rst_n) m_valid = 1'b1;
        end
    end

    initial begin : stimulus
        int ni, nd, c0;
        rst_n = 1'b0;
        drive(1'b1, 30'h1abc, 1'b1, 30'h55);

        // Reset with both buses requesting, then release: I gets the first grant.
        repeat (3) step();
        @(negedge clk);
        check("reset i_ack", {31'h0, rr_i_ack}, 32'h0);
        check("reset d_ack", {31'h0, rr_d_ack}, 32'h0);
        check("reset i_data", rr_i_data, 32'h0);
        check("reset d_data", rr_d_data, 32'h0);
        check("reset cnt", {16'h0, rr_cnt}, 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("release rom_en", {31'h0, rr_rom_en}, 32'h1);
        check("release rom_addr", {21'h0, rr_rom_addr}, 32'h2bc);
        step();
        drive(1'b0, 30'h0, 1'b0, 30'h0);
        @(negedge clk);
        check("release i_ack", {31'h0, rr_i_ack}, 32'h1);
        check("release i_data", rr_i_data, rom_fn(11'h2bc));
        check("release d_ack", {31'h0, rr_d_ack}, 32'h0);

        // Round-robin conflict right after reset: I first, then D.
        step();
        do_reset();
        drive(1'b1, 30'h10, 1'b1, 30'h20);
        @(negedge clk);
        check("conflict rom_addr I", {21'h0, rr_rom_addr}, 32'h10);
        step();
        drive(1'b0, 30'h0, 1'b1, 30'h20);
        @(negedge clk);
        check("conflict i_ack", {31'h0, rr_i_ack}, 32'h1);
        check("conflict i_data", rr_i_data, rom_fn(11'h10));
        check("conflict rom_addr D", {21'h0, rr_rom_addr}, 32'h20);
        step();
        drive(1'b0, 30'h0, 1'b0, 30'h0);
        @(negedge clk);
        check("conflict d_ack", {31'h0, rr_d_ack}, 32'h1);
        check("conflict d_data", rr_d_data, rom_fn(11'h20));
        check("conflict cnt", {16'h0, rr_cnt}, 32'h1);

        // Instruction bus streams alone: one ack per cycle.
        for (int a = 0; a <= 4; a++) begin
            step();
            if (a < 4) drive(1'b1, 30'(a), 1'b0, 30'h0);
            else       drive(1'b0, 30'h0, 1'b0, 30'h0);
            @(negedge clk);
            if (a > 0) begin
                check("stream i_ack", {31'h0, rr_i_ack}, 32'h1);
                check("stream i_data", rr_i_data, rom_fn(11'(a - 1)));
                check("stream d_ack", {31'h0, rr_d_ack}, 32'h0);
                check("stream d_data", rr_d_data, 32'h0);
            end
        end

        // Both buses request for 8 cycles: the grants alternate.
        c0 = int'(rr_cnt);
        ni = 0;
        nd = 0;
        for (int c = 0; c <= 8; c++) begin
            step();
            if (c < 8) drive(1'b1, 30'(c), 1'b1, 30'(12'h100 + c));
            else       drive(1'b0, 30'h0, 1'b0, 30'h0);
            @(negedge clk);
            if (c > 0) begin
                ni += int'(rr_i_ack);
                nd += int'(rr_d_ack);
            end
        end
        check("alternate i acks", ni, 4);
        check("alternate d acks", nd, 4);
        check("alternate cnt delta", int'(rr_cnt) - c0, 8);

        // Fixed priority: while I keeps requesting, D never wins.
        ni = 0;
        nd = 0;
        for (int c = 0; c <= 5; c++) begin
            step();
            if (c < 5) drive(1'b1, 30'(12'h40 + c), 1'b1, 30'h77);
            else       drive(1'b0, 30'h0, 1'b0, 30'h0);
            @(negedge clk);
            if (c > 0) begin
                ni += int'(fp_i_ack);
                nd += int'(fp_d_ack);
            end
        end
        check("fixed i acks", ni, 5);
        check("fixed d acks", nd, 0);

        // The 4-bit counter saturates at 15 and stays there.
        step();
        do_reset();
        drive(1'b1, 30'h3, 1'b1, 30'h4);
        repeat (22) step();
        drive(1'b0, 30'h0, 1'b0, 30'h0);
        @(negedge clk);
        check("saturate sat cnt", {28'h0, sat_cnt}, 32'd15);
        check("saturate rr cnt", {16'h0, rr_cnt}, 32'd22);

        // Random traffic, with an occasional reset.
        for (int n = 0; n < 3000; n++) begin
            step();
            rst_n    = ($urandom_range(0, 99) != 0);
            i_access = ($urandom_range(0, 9) < 7);
            i_cs     = ($urandom_range(0, 9) < 8);
            d_access = ($urandom_range(0, 9) < 7);
            d_cs     = ($urandom_range(0, 9) < 8);
            i_addr   = 30'($urandom);
            d_addr   = 30'($urandom);
        end
        step();
        rst_n = 1'b1;
        drive(1'b0, 30'h0, 1'b0, 30'h0);
        repeat (2) step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
